// File: rtl/obi_rr_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : obi_rr_arbiter
// Purpose  : Round-robin arbiter that shares one downstream OBI slave port
//            between NUM_REQ OBI masters. Only one transaction is outstanding
//            at a time. The grant is locked from request until response, and
//            the response is routed back to the owning master only. A response
//            watchdog synthesises an error response if the downstream port
//            never answers.
// Ports    : obi_clk_i, rst_ni     clock, asynchronous active-low reset
//            en_i                  arbitration enable (affects IDLE only)
//            m_*                   NUM_REQ upstream masters, packed buses
//            s_*                   downstream OBI port
//            busy_o / owner_o      lock status and locked master index
//            timeout_o             one-cycle pulse when the watchdog fires
// Revision : 1.0 - initial release
// ============================================================================
module obi_rr_arbiter #(
  parameter  int                NUM_REQ     = 2,
  parameter  int                ADDR_W      = 32,
  parameter  int                DATA_W      = 32,
  parameter  int                TIMEOUT_CYC = 256,
  parameter  logic [DATA_W-1:0] ERR_RDATA   = 32'hBADC_0FFE,
  localparam int                IDX_W       = $clog2(NUM_REQ),
  localparam int                BE_W        = DATA_W / 8
) (
  input  logic                      obi_clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  // upstream masters
  input  logic [NUM_REQ-1:0]        m_req_i,
  output logic [NUM_REQ-1:0]        m_gnt_o,
  input  logic [NUM_REQ*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_REQ-1:0]        m_wr_en_i,
  input  logic [NUM_REQ*BE_W-1:0]   m_byte_en_i,
  input  logic [NUM_REQ*DATA_W-1:0] m_wdata_i,
  output logic [NUM_REQ-1:0]        m_rvalid_o,
  output logic [DATA_W-1:0]         m_rdata_o,
  // downstream slave port
  output logic                      s_req_o,
  input  logic                      s_gnt_i,
  output logic [ADDR_W-1:0]         s_addr_o,
  output logic                      s_wr_en_o,
  output logic [BE_W-1:0]           s_byte_en_o,
  output logic [DATA_W-1:0]         s_wdata_o,
  input  logic                      s_rvalid_i,
  input  logic [DATA_W-1:0]         s_rdata_i,
  // status
  output logic                      busy_o,
  output logic [IDX_W-1:0]          owner_o,
  output logic                      timeout_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // The watchdog counter only ever needs to reach TIMEOUT_CYC-1.
  localparam int              WD_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] C_WD_LAST  = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;
  localparam bit              C_WD_EN    = (TIMEOUT_CYC != 0);
  // One extra bit so rr + offset cannot overflow before the modulo compare.
  localparam logic [IDX_W:0]  C_NUM_REQ  = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           r_state;
  logic [IDX_W-1:0] r_idx;   // locked owner
  logic [IDX_W-1:0] r_rr;    // round-robin start pointer
  logic [WD_W-1:0]  r_wd;    // response watchdog

  // --------------------------------------------------------------------------
  // Unpacked views of the packed master buses
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_addr  [NUM_REQ];
  logic [BE_W-1:0]   w_be    [NUM_REQ];
  logic [DATA_W-1:0] w_wdata [NUM_REQ];

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic             w_in_req;
  logic             w_in_resp;
  logic             w_own_req;
  logic             w_gnt_fwd;
  logic             w_timeout;
  logic             w_rsp_fwd;
  logic             w_win_valid;
  logic [IDX_W-1:0] w_win_idx;
  logic [IDX_W-1:0] w_rr_next;

  assign w_in_req  = (r_state == ST_REQ);
  assign w_in_resp = (r_state == ST_RESP);
  assign w_own_req = m_req_i[r_idx];

  // A grant is only forwarded while the owner is still requesting; a grant
  // that races an abort is dropped together with the abort.
  assign w_gnt_fwd = w_in_req && w_own_req && s_gnt_i;

  // The watchdog fires on the last allowed RESP cycle, and only if the real
  // response does not arrive in that very cycle.
  assign w_timeout = C_WD_EN && w_in_resp && !s_rvalid_i && (r_wd == C_WD_LAST);
  assign w_rsp_fwd = w_in_resp && (s_rvalid_i || w_timeout);

  // Next round-robin pointer: explicit wrap so non-power-of-two NUM_REQ
  // never lands on an index that does not exist.
  assign w_rr_next = (r_idx == C_LAST_IDX) ? '0 : (r_idx + 1'b1);

  // Winner selection: first requesting master at or after r_rr, wrapping.
  // The scan runs from the farthest offset down so the nearest requester is
  // the last one assigned and therefore wins.
  always_comb begin
    logic [IDX_W:0] cand;
    cand        = '0;
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, r_rr} + (IDX_W + 1)'(i);
      if (cand >= C_NUM_REQ) begin
        cand = cand - C_NUM_REQ;
      end
      if (m_req_i[cand[IDX_W-1:0]]) begin
        w_win_valid = 1'b1;
        w_win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-master unpacking and response/grant demux
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_master
    assign w_addr[k]     = m_addr_i[k*ADDR_W +: ADDR_W];
    assign w_be[k]       = m_byte_en_i[k*BE_W +: BE_W];
    assign w_wdata[k]    = m_wdata_i[k*DATA_W +: DATA_W];
    assign m_gnt_o[k]    = w_gnt_fwd && (r_idx == IDX_W'(k));
    assign m_rvalid_o[k] = w_rsp_fwd && (r_idx == IDX_W'(k));
  end

  // --------------------------------------------------------------------------
  // Downstream request mux: everything is forced to zero outside REQ so the
  // slave never sees stale addresses or data.
  // --------------------------------------------------------------------------
  assign s_req_o     = w_in_req && w_own_req;
  assign s_addr_o    = w_in_req ? w_addr[r_idx]    : '0;
  assign s_wr_en_o   = w_in_req && m_wr_en_i[r_idx];
  assign s_byte_en_o = w_in_req ? w_be[r_idx]      : '0;
  assign s_wdata_o   = w_in_req ? w_wdata[r_idx]   : '0;

  // Shared read data, qualified by m_rvalid_o; zero outside RESP.
  always_comb begin
    m_rdata_o = '0;
    if (w_in_resp) begin
      m_rdata_o = w_timeout ? ERR_RDATA : s_rdata_i;
    end
  end

  assign busy_o    = (r_state != ST_IDLE);
  assign owner_o   = busy_o ? r_idx : '0;
  assign timeout_o = w_timeout;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge obi_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_rr    <= '0;
      r_wd    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Stale s_gnt_i / s_rvalid_i are simply not looked at here.
          if (en_i && w_win_valid) begin
            r_idx   <= w_win_idx;
            r_state <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (!w_own_req) begin
            // Master withdrew before the grant: release the lock without
            // advancing the pointer so it keeps its turn.
            r_state <= ST_IDLE;
          end else if (s_gnt_i) begin
            r_state <= ST_RESP;
            r_wd    <= '0;
          end
        end

        ST_RESP: begin
          if (s_rvalid_i || w_timeout) begin
            r_state <= ST_IDLE;
            r_rr    <= w_rr_next;
          end else if (r_wd != C_WD_LAST) begin
            r_wd <= r_wd + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_rr_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_obi_rr_arbiter
// Purpose  : Self-checking bench for obi_rr_arbiter. Instance A has two
//            masters and an 8-cycle watchdog, instance B has three masters
//            for the non-power-of-two wrap. Expected responses are pushed to
//            per-instance queues and popped by a monitor when m_rvalid_o fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obi_rr_arbiter;

  localparam int TO = 8;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- instance A (2 masters) ----------------
  logic        en_a;
  logic [1:0]  req_a, gnt_a, wr_a, rvalid_a;
  logic [63:0] addr_a, wdata_a;
  logic [7:0]  be_a;
  logic [31:0] mrdata_a;
  logic        sreq_a, sgnt_a, swr_a, srvalid_a, busy_a, timeout_a;
  logic [31:0] saddr_a, swdata_a, srdata_a;
  logic [3:0]  sbe_a;
  logic [0:0]  owner_a;

  // ---------------- instance B (3 masters) ----------------
  logic        en_b;
  logic [2:0]  req_b, gnt_b, wr_b, rvalid_b;
  logic [95:0] addr_b, wdata_b;
  logic [11:0] be_b;
  logic [31:0] mrdata_b;
  logic        sreq_b, sgnt_b, swr_b, srvalid_b, busy_b, timeout_b;
  logic [31:0] saddr_b, swdata_b, srdata_b;
  logic [3:0]  sbe_b;
  logic [1:0]  owner_b;

  obi_rr_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO),
                   .ERR_RDATA(32'hBADC_0FFE)) u_dut_a (
    .obi_clk_i(clk), .rst_ni(rst_n), .en_i(en_a),
    .m_req_i(req_a), .m_gnt_o(gnt_a), .m_addr_i(addr_a), .m_wr_en_i(wr_a),
    .m_byte_en_i(be_a), .m_wdata_i(wdata_a), .m_rvalid_o(rvalid_a),
    .m_rdata_o(mrdata_a),
    .s_req_o(sreq_a), .s_gnt_i(sgnt_a), .s_addr_o(saddr_a), .s_wr_en_o(swr_a),
    .s_byte_en_o(sbe_a), .s_wdata_o(swdata_a), .s_rvalid_i(srvalid_a),
    .s_rdata_i(srdata_a),
    .busy_o(busy_a), .owner_o(owner_a), .timeout_o(timeout_a)
  );

  obi_rr_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO),
                   .ERR_RDATA(32'hBADC_0FFE)) u_dut_b (
    .obi_clk_i(clk), .rst_ni(rst_n), .en_i(en_b),
    .m_req_i(req_b), .m_gnt_o(gnt_b), .m_addr_i(addr_b), .m_wr_en_i(wr_b),
    .m_byte_en_i(be_b), .m_wdata_i(wdata_b), .m_rvalid_o(rvalid_b),
    .m_rdata_o(mrdata_b),
    .s_req_o(sreq_b), .s_gnt_i(sgnt_b), .s_addr_o(saddr_b), .s_wr_en_o(swr_b),
    .s_byte_en_o(sbe_b), .s_wdata_o(swdata_b), .s_rvalid_i(srvalid_b),
    .s_rdata_i(srdata_b),
    .busy_o(busy_b), .owner_o(owner_b), .timeout_o(timeout_b)
  );

  // ---------------- per-master stimulus tables ----------------
  function automatic logic [31:0] e_addr(bit sel, int k);
    return (sel ? 32'h0000_2000 : 32'h0000_1000) + 32'(k) * 32'h100;
  endfunction
  function automatic logic e_wr(int k);
    return (k == 1);
  endfunction
  function automatic logic [31:0] e_wdata(int k);
    return 32'hA5A5_0000 + 32'(k);
  endfunction
  function automatic logic [3:0] e_be(int k);
    return (k == 0) ? 4'hF : ((k == 1) ? 4'h3 : 4'hC);
  endfunction

  // ---------------- accessors selecting an instance ----------------
  function automatic logic f_sreq(bit sel);    return sel ? sreq_b : sreq_a;       endfunction
  function automatic logic f_busy(bit sel);    return sel ? busy_b : busy_a;       endfunction
  function automatic logic f_tmo(bit sel);     return sel ? timeout_b : timeout_a; endfunction
  function automatic logic f_swr(bit sel);     return sel ? swr_b : swr_a;         endfunction
  function automatic logic [31:0] f_saddr(bit sel);  return sel ? saddr_b : saddr_a;   endfunction
  function automatic logic [31:0] f_swdata(bit sel); return sel ? swdata_b : swdata_a; endfunction
  function automatic logic [3:0]  f_sbe(bit sel);    return sel ? sbe_b : sbe_a;       endfunction
  function automatic logic [2:0]  f_gnt(bit sel);    return sel ? gnt_b : {1'b0, gnt_a};       endfunction
  function automatic logic [2:0]  f_rv(bit sel);     return sel ? rvalid_b : {1'b0, rvalid_a}; endfunction
  function automatic logic [1:0]  f_owner(bit sel);  return sel ? owner_b : {1'b0, owner_a};   endfunction

  task automatic set_req(bit sel, logic [2:0] v);
    if (sel) req_b = v; else req_a = v[1:0];
  endtask
  task automatic set_gnt(bit sel, logic v);
    if (sel) sgnt_b = v; else sgnt_a = v;
  endtask
  task automatic set_rv(bit sel, logic v, logic [31:0] d);
    if (sel) begin srvalid_b = v; srdata_b = d; end
    else     begin srvalid_a = v; srdata_a = d; end
  endtask
  task automatic push(bit sel, exp_t e);
    if (sel) qb.push_back(e); else qa.push_back(e);
  endtask

  // ---------------- response monitor / scoreboard ----------------
  always begin : mon
    exp_t e;
    @(negedge clk);
    #3;
    if (rst_n === 1'b1) begin
      checks++;
      if ($countones(gnt_a) > 1 || $countones(gnt_b) > 1) begin
        errors++;
        $display("FAIL gnt_onehot gnt_a=%b gnt_b=%b at most one bit required", gnt_a, gnt_b);
      end
      if (rvalid_a !== 2'b00) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL rsp_a_unexpected rvalid=%b rdata=%h none expected", rvalid_a, mrdata_a);
        end else begin
          e = qa.pop_front();
          if (rvalid_a !== 2'(1 << e.idx) || mrdata_a !== e.data) begin
            errors++;
            $display("FAIL rsp_a rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                     rvalid_a, mrdata_a, 2'(1 << e.idx), e.data);
          end
        end
      end
      if (rvalid_b !== 3'b000) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL rsp_b_unexpected rvalid=%b rdata=%h none expected", rvalid_b, mrdata_b);
        end else begin
          e = qb.pop_front();
          if (rvalid_b !== 3'(1 << e.idx) || mrdata_b !== e.data) begin
            errors++;
            $display("FAIL rsp_b rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                     rvalid_b, mrdata_b, 3'(1 << e.idx), e.data);
          end
        end
      end
    end
  end

  // ---------------- one complete transaction ----------------
  // Starts on an IDLE cycle, ends on the response (or watchdog) cycle so that
  // consecutive calls run back to back.
  task automatic txn(input bit sel, input logic [2:0] req, input int own,
                     input int gdly, input int rdly, input logic [31:0] rd,
                     input bit wd);
    exp_t e;
    @(negedge clk);
    set_gnt(sel, 1'b0); set_rv(sel, 1'b0, '0); set_req(sel, req);
    #1;
    checks++;
    if (f_sreq(sel) !== 1'b0 || f_busy(sel) !== 1'b0) begin
      errors++;
      $display("FAIL txn_idle sel=%0d s_req=%b busy=%b expected 0 0", sel, f_sreq(sel), f_busy(sel));
    end
    for (int i = 0; i < gdly; i++) begin
      @(negedge clk); #1;
      checks++;
      if (f_sreq(sel) !== 1'b1 || f_owner(sel) !== 2'(own) || f_gnt(sel) !== 3'b000) begin
        errors++;
        $display("FAIL txn_req sel=%0d s_req=%b owner=%0d gnt=%b expected 1 %0d 000",
                 sel, f_sreq(sel), f_owner(sel), f_gnt(sel), own);
      end
    end
    @(negedge clk);
    set_gnt(sel, 1'b1);
    #1;
    checks++;
    if (f_gnt(sel) !== 3'(1 << own) || f_owner(sel) !== 2'(own) || f_sreq(sel) !== 1'b1) begin
      errors++;
      $display("FAIL txn_gnt sel=%0d gnt=%b owner=%0d s_req=%b expected %b %0d 1",
               sel, f_gnt(sel), f_owner(sel), f_sreq(sel), 3'(1 << own), own);
    end
    checks++;
    if (f_saddr(sel) !== e_addr(sel, own) || f_swr(sel) !== e_wr(own) ||
        f_sbe(sel) !== e_be(own) || f_swdata(sel) !== e_wdata(own)) begin
      errors++;
      $display("FAIL txn_mux sel=%0d addr=%h wr=%b be=%h wdata=%h expected %h %b %h %h",
               sel, f_saddr(sel), f_swr(sel), f_sbe(sel), f_swdata(sel),
               e_addr(sel, own), e_wr(own), e_be(own), e_wdata(own));
    end
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      set_gnt(sel, 1'b0);
      #1;
      checks++;
      if (f_sreq(sel) !== 1'b0 || f_rv(sel) !== 3'b000 || f_tmo(sel) !== 1'b0 ||
          f_busy(sel) !== 1'b1 || f_saddr(sel) !== 32'h0) begin
        errors++;
        $display("FAIL txn_wait sel=%0d s_req=%b rvalid=%b timeout=%b busy=%b addr=%h expected 0 000 0 1 0",
                 sel, f_sreq(sel), f_rv(sel), f_tmo(sel), f_busy(sel), f_saddr(sel));
      end
    end
    @(negedge clk);
    set_gnt(sel, 1'b0);
    e.idx = own;
    if (wd) begin
      e.data = 32'hBADC_0FFE;
    end else begin
      e.data = rd;
      set_rv(sel, 1'b1, rd);
    end
    push(sel, e);
    #1;
    checks++;
    if (f_tmo(sel) !== wd) begin
      errors++;
      $display("FAIL txn_timeout sel=%0d timeout=%b expected %b", sel, f_tmo(sel), wd);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    set_req(0, '0); set_req(1, '0);
    set_gnt(0, 1'b0); set_gnt(1, 1'b0);
    set_rv(0, 1'b0, '0); set_rv(1, 1'b0, '0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    en_a = 1'b1; en_b = 1'b1;
    req_a = 2'b11; req_b = 3'b111;
    sgnt_a = 1'b1; sgnt_b = 1'b1;
    srvalid_a = 1'b1; srvalid_b = 1'b1;
    srdata_a = 32'hFFFF_FFFF; srdata_b = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({gnt_a, rvalid_a, mrdata_a, sreq_a, saddr_a, swr_a, sbe_a, swdata_a,
         busy_a, owner_a, timeout_a} !== '0) begin
      errors++;
      $display("FAIL reset_a gnt=%b rv=%b rdata=%h sreq=%b addr=%h busy=%b expected all zero",
               gnt_a, rvalid_a, mrdata_a, sreq_a, saddr_a, busy_a);
    end
    checks++;
    if ({gnt_b, rvalid_b, mrdata_b, sreq_b, saddr_b, swr_b, sbe_b, swdata_b,
         busy_b, owner_b, timeout_b} !== '0) begin
      errors++;
      $display("FAIL reset_b gnt=%b rv=%b rdata=%h sreq=%b addr=%h busy=%b expected all zero",
               gnt_b, rvalid_b, mrdata_b, sreq_b, saddr_b, busy_b);
    end
    go_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    txn(0, 3'b001, 0, 2, 3, 32'h1234_5678, 0);
    // Pointer moved to 1: master 1 wins a tie next.
    txn(0, 3'b011, 1, 0, 0, 32'h0000_0111, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      txn(0, 3'b011, i % 2, 0, 0, 32'hC0DE_0000 + 32'(i), 0);
    end
  endtask

  task automatic test_enable();
    @(negedge clk);
    set_rv(0, 1'b0, '0);
    en_a = 1'b0;
    set_req(0, 3'b001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (busy_a !== 1'b0 || sreq_a !== 1'b0) begin
        errors++;
        $display("FAIL enable_hold busy=%b s_req=%b expected 0 0", busy_a, sreq_a);
      end
    end
    @(negedge clk);
    set_req(0, 3'b000);
    en_a = 1'b1;
  endtask

  task automatic test_abort();
    txn(0, 3'b001, 0, 0, 1, 32'h0000_AB00, 0);
    @(negedge clk);
    set_rv(0, 1'b0, '0);
    set_req(0, 3'b010);
    @(negedge clk); #1;
    checks++;
    if (sreq_a !== 1'b1 || owner_a !== 1'b1 || gnt_a !== 2'b00) begin
      errors++;
      $display("FAIL abort_req s_req=%b owner=%0d gnt=%b expected 1 1 00", sreq_a, owner_a, gnt_a);
    end
    @(negedge clk);
    set_req(0, 3'b000);
    set_gnt(0, 1'b1);
    #1;
    checks++;
    if (sreq_a !== 1'b0 || gnt_a !== 2'b00) begin
      errors++;
      $display("FAIL abort_drop s_req=%b gnt=%b expected 0 00", sreq_a, gnt_a);
    end
    @(negedge clk);
    set_gnt(0, 1'b0);
    #1;
    checks++;
    if (busy_a !== 1'b0 || rvalid_a !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle busy=%b rvalid=%b expected 0 00", busy_a, rvalid_a);
    end
    // Pointer untouched by the abort: master 1 still has priority.
    txn(0, 3'b011, 1, 0, 0, 32'h0000_AB01, 0);
  endtask

  task automatic test_watchdog();
    txn(0, 3'b001, 0, 1, TO - 1, 32'h0, 1);
    @(negedge clk);
    set_req(0, 3'b000);
    set_gnt(0, 1'b1);
    set_rv(0, 1'b1, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (busy_a !== 1'b0 || rvalid_a !== 2'b00 || gnt_a !== 2'b00 ||
        timeout_a !== 1'b0 || mrdata_a !== 32'h0) begin
      errors++;
      $display("FAIL stale_rsp busy=%b rvalid=%b gnt=%b timeout=%b rdata=%h expected all zero",
               busy_a, rvalid_a, gnt_a, timeout_a, mrdata_a);
    end
    @(negedge clk);
    set_gnt(0, 1'b0);
    set_rv(0, 1'b0, '0);
    txn(0, 3'b011, 1, 0, 0, 32'h0000_0D01, 0);
  endtask

  task automatic test_reset_mid();
    txn(0, 3'b001, 0, 0, 0, 32'h0000_5E00, 0);
    @(negedge clk);
    set_rv(0, 1'b0, '0);
    set_req(0, 3'b010);
    @(negedge clk);
    set_gnt(0, 1'b1);
    #1;
    checks++;
    if (gnt_a !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_gnt gnt=%b expected 10", gnt_a);
    end
    @(negedge clk);
    set_gnt(0, 1'b0);
    srdata_a = 32'h5555_AAAA;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt_a, rvalid_a, mrdata_a, sreq_a, saddr_a, swr_a, sbe_a, swdata_a,
         busy_a, owner_a, timeout_a} !== '0) begin
      errors++;
      $display("FAIL rstmid_out busy=%b owner=%0d rdata=%h rvalid=%b expected all zero",
               busy_a, owner_a, mrdata_a, rvalid_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 3'b000);
    srdata_a = 32'h0;
    // Pointer is back at 0 after reset.
    txn(0, 3'b011, 0, 1, 2, 32'h0000_5E01, 0);
  endtask

  task automatic test_three_masters();
    txn(1, 3'b001, 0, 0, 0, 32'h3000_0000, 0);
    txn(1, 3'b101, 2, 0, 1, 32'h3000_0002, 0);
    txn(1, 3'b101, 0, 0, 0, 32'h3000_0010, 0);
    txn(1, 3'b110, 1, 1, 0, 32'h3000_0011, 0);
    txn(1, 3'b111, 2, 0, 0, 32'h3000_0012, 0);
    txn(1, 3'b111, 0, 0, 0, 32'h3000_0020, 0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    addr_a  = {e_addr(0, 1), e_addr(0, 0)};
    addr_b  = {e_addr(1, 2), e_addr(1, 1), e_addr(1, 0)};
    wr_a    = {e_wr(1), e_wr(0)};
    wr_b    = {e_wr(2), e_wr(1), e_wr(0)};
    be_a    = {e_be(1), e_be(0)};
    be_b    = {e_be(2), e_be(1), e_be(0)};
    wdata_a = {e_wdata(1), e_wdata(0)};
    wdata_b = {e_wdata(2), e_wdata(1), e_wdata(0)};

    test_reset();
    test_single();
    test_back_to_back();
    test_enable();
    test_abort();
    test_watchdog();
    test_reset_mid();
    test_three_masters();
    go_idle();
    repeat (3) @(negedge clk);

    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL rsp_missing pending_a=%0d pending_b=%0d expected 0 0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded bound");
    $fatal(1, "bench did not finish");
  end

endmodule
`default_nettype wire
